// File: rtl/stage_queue.sv
// stage_queue: small synchronous FIFO used between pipeline stages.
// Holds up to DEPTH entries of WIDTH bits, supports a synchronous flush for
// branch redirects, and reports its occupancy. in_ready depends on registered
// state only, so no combinational path exists from out_ready to in_ready.
//
// Optional feature: define STAGE_QUEUE_BYPASS_EN to enable cut-through. While
// the queue is empty, an offered entry is presented on out_data in the same
// cycle; if it is also consumed that cycle it is never stored.
module stage_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic empty, full;
    logic push, pop;
    logic bypass_take;   // entry handed straight through, never stored
    logic store, deq;    // storage write / storage read-pointer advance

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

`ifdef STAGE_QUEUE_BYPASS_EN
    // Empty queue exposes the offered entry directly on the output.
    assign bypass_take = empty && in_valid && out_ready && !flush;
    assign out_valid   = !empty || (in_valid && !flush);
    assign out_data    = empty ? in_data : mem_q[rd_ptr_q];
`else
    // Outputs come from registered state only.
    assign bypass_take = 1'b0;
    assign out_valid   = !empty;
    assign out_data    = mem_q[rd_ptr_q];
`endif

    assign push  = in_valid && in_ready && !flush;
    assign pop   = out_valid && out_ready && !flush;
    assign store = push && !bypass_take;
    assign deq   = pop && !bypass_take;

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural wrap gives modulo DEPTH.
            if (store) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq)   rd_ptr_d = rd_ptr_q + PW'(1);
            case ({store, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage write on accepted, non-bypassed pushes.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count_q guards validity,
        // and leaving it unreset lets it map onto plain RAM/flops cheaply.
        if (store) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: doc/stage_queue.md
STAGE_QUEUE -- requirements
Module: stage_queue

Interface
REQ-001: Parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002: Parameter DEPTH, default 2, entry count; power of two, >=2.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: flush  input  1  synchronous discard of all entries (branch redirect).
REQ-006: in_valid  input  1  upstream stage offers in_data.
REQ-007: in_ready  output  1  queue accepts in_data this cycle.
REQ-008: in_data  input  WIDTH  upstream payload.
REQ-009: out_valid  output  1  out_data holds a valid entry.
REQ-010: out_ready  input  1  downstream stage consumes out_data this cycle.
REQ-011: out_data  output  WIDTH  head-of-queue payload.
REQ-012: count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-013: Push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
REQ-014: in_ready SHALL be (count != DEPTH), derived from registered state only; no combinational path from out_ready.
REQ-015: out_valid SHALL be (count != 0) when bypass is absent; out_data SHALL be the head entry.
REQ-016: Push writes in_data at write pointer, pointer +1 modulo DEPTH; pop advances read pointer +1 modulo DEPTH.
REQ-017: Push only: count +1; pop only: count -1; push and pop same cycle: count unchanged, both pointers advance.
REQ-018: Full (count==DEPTH): in_ready=0, in_valid ignored, including when a pop occurs that cycle.
REQ-019: Empty (count==0): out_valid=0 (bypass absent); out_data is don't-care.
REQ-020: Latency push to out_valid: 1 cycle when empty; entries leave in strict FIFO order.
REQ-021: While out_valid=1 and out_ready=0, out_data and out_valid SHALL stay stable until pop or flush.
REQ-022: flush=1: next cycle count=0, both pointers=0, out_valid=0; a push or pop in the flush cycle has no effect; flush overrides everything except rst.
REQ-023: flush held multiple cycles keeps the queue empty; in_ready=1 throughout.

Reset
REQ-024: rst=1 asynchronously sets count=0, read/write pointers=0; outputs then: in_ready=1, out_valid=0, count=0.
REQ-025: rst asserted mid-operation discards all stored entries immediately, regardless of clk; storage array contents need not be reset.
REQ-026: First push accepted on first rising edge after rst deasserts.

Configuration
REQ-027: Macro STAGE_QUEUE_BYPASS_EN, when defined, enables cut-through: when count==0, in_valid=1, out_ready=1, flush=0, then out_valid=1, out_data=in_data combinationally, entry is not stored, count stays 0.
REQ-028: With STAGE_QUEUE_BYPASS_EN, when count==0 and out_ready=0, in_valid is stored normally and out_valid=in_valid combinationally with out_data=in_data; REQ-021 stability applies from the following cycle.
REQ-029: Without STAGE_QUEUE_BYPASS_EN, out_valid and out_data depend only on registered state; zero-latency pass-through never occurs.

Verification (WIDTH=32, DEPTH=2, bypass off unless stated)
REQ-030: rst pulse mid-cycle with count=2 -> count=0, out_valid=0, in_ready=1 before next clk edge.
REQ-031: Push 0x11111111, 0x22222222 with out_ready=0 -> count=2, in_ready=0; third offer 0x33333333 not accepted; out_ready=1 -> outputs 0x11111111 then 0x22222222.
REQ-032: count=1 (head 0xA), simultaneous push 0xB and pop -> count stays 1, out_data=0xB next cycle; repeat 5 times -> pointer wrap, order preserved.
REQ-033: count=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, nothing popped downstream, pushed value absent.
REQ-034: out_ready=0 for 4 cycles with head 0xDEADBEEF -> out_data constant 0xDEADBEEF, out_valid=1 every cycle.
REQ-035: Bypass on, empty, in_valid=1 in_data=0xCAFE0001 out_ready=1 -> same-cycle out_valid=1, out_data=0xCAFE0001, count stays 0.
